// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter between instruction fetch and the MEM stage.
// Latches one request, runs the per-byte RAM sequence and returns a done pulse.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter bit          MEM_FIRST  = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,

  input  logic                  if_req_in,
  input  logic [ADDR_WIDTH-1:0] if_addr_in,
  input  logic                  if_flush_in,
  output logic                  if_done_out,
  output logic [31:0]           if_data_out,

  input  logic                  mem_load_in,
  input  logic                  mem_store_in,
  input  logic [ADDR_WIDTH-1:0] mem_addr_in,
  input  logic [1:0]            mem_width_in,
  input  logic [31:0]           mem_wdata_in,
  output logic                  mem_done_out,
  output logic [31:0]           mem_rdata_out,

  output logic                  busy_out,

  input  logic [7:0]            ram_din_in,
  output logic [7:0]            ram_dout_out,
  output logic [ADDR_WIDTH-1:0] ram_a_out,
  output logic                  ram_wr_out
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e state_q, state_d;

  // Latched request
  logic                  owner_if_q, owner_if_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            n_q, n_d;
  logic [31:0]           wdata_q, wdata_d;

  // Sequencing: k counts issued addresses, c counts captured bytes
  logic [2:0]            k_q, k_d;
  logic [2:0]            c_q, c_d;
  logic                  lat_q, lat_d;
  logic [31:0]           buf_q, buf_d;

  // Registered outputs
  logic [ADDR_WIDTH-1:0] ram_a_q, ram_a_d;
  logic [7:0]            ram_dout_q, ram_dout_d;
  logic                  ram_wr_q, ram_wr_d;
  logic                  if_done_q, if_done_d;
  logic [31:0]           if_data_q, if_data_d;
  logic                  mem_done_q, mem_done_d;
  logic [31:0]           mem_rdata_q, mem_rdata_d;
  logic                  busy_q, busy_d;

  logic                  if_go;
  logic                  mem_go;
  logic                  pick_if;
  logic                  flush_hit;
  logic                  rd_last;
  logic [31:0]           buf_new;
  logic [ADDR_WIDTH-1:0] addr_next;

  function automatic logic [2:0] width_bytes(input logic [1:0] w);
    logic [2:0] n;
    unique case (w)
      2'd0:    n = 3'd1;
      2'd1:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  assign if_go     = if_req_in && !if_flush_in;
  assign mem_go    = mem_load_in || mem_store_in;
  assign pick_if   = if_go && (!mem_go || !MEM_FIRST);
  assign flush_hit = (state_q == StRd) && owner_if_q && if_flush_in;
  // The first RD cycle only primes the RAM pipeline; captures start one cycle later
  assign rd_last   = (state_q == StRd) && lat_q && (c_q == n_q - 3'd1);
  assign addr_next = addr_q + {{(ADDR_WIDTH-3){1'b0}}, k_q};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= StIdle;
    end else if (rdy_in) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pick_if)           state_d = StRd;
        else if (mem_store_in) state_d = StWr;
        else if (mem_load_in)  state_d = StRd;
      end
      StRd: begin
        if (flush_hit)    state_d = StIdle;
        else if (rd_last) state_d = StDone;
      end
      StWr: begin
        if (k_q == n_q) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    owner_if_d  = owner_if_q;
    addr_d      = addr_q;
    n_d         = n_q;
    wdata_d     = wdata_q;
    k_d         = k_q;
    c_d         = c_q;
    lat_d       = lat_q;
    buf_d       = buf_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = ram_wr_q;
    if_done_d   = 1'b0;
    if_data_d   = if_data_q;
    mem_done_d  = 1'b0;
    mem_rdata_d = mem_rdata_q;
    busy_d      = (state_d != StIdle);

    buf_new = buf_q;
    buf_new[{c_q[1:0], 3'b000} +: 8] = ram_din_in;

    unique case (state_q)
      StIdle: begin
        if (state_d != StIdle) begin
          owner_if_d = pick_if;
          addr_d     = pick_if ? if_addr_in : mem_addr_in;
          ram_a_d    = pick_if ? if_addr_in : mem_addr_in;
          n_d        = pick_if ? 3'd4 : width_bytes(mem_width_in);
          wdata_d    = mem_wdata_in;
          k_d        = 3'd1;
          c_d        = 3'd0;
          lat_d      = 1'b0;
          buf_d      = '0;
          ram_wr_d   = (state_d == StWr);
          if (state_d == StWr) ram_dout_d = mem_wdata_in[7:0];
        end
      end
      StRd: begin
        ram_wr_d = 1'b0;
        if (!flush_hit) begin
          if (lat_q) begin
            buf_d = buf_new;
            c_d   = c_q + 3'd1;
            if (rd_last) begin
              if (owner_if_q) begin
                if_done_d = 1'b1;
                if_data_d = buf_new;
              end else begin
                mem_done_d  = 1'b1;
                mem_rdata_d = buf_new;
              end
            end
          end else begin
            lat_d = 1'b1;
          end
          if (k_q < n_q) begin
            ram_a_d = addr_next;
            k_d     = k_q + 3'd1;
          end
        end
      end
      StWr: begin
        if (k_q < n_q) begin
          ram_a_d    = addr_next;
          ram_dout_d = wdata_q[{k_q[1:0], 3'b000} +: 8];
          k_d        = k_q + 3'd1;
        end else begin
          ram_wr_d   = 1'b0;
          mem_done_d = 1'b1;
        end
      end
      StDone:  ram_wr_d = 1'b0;
      default: ram_wr_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      owner_if_q  <= 1'b0;
      addr_q      <= '0;
      n_q         <= '0;
      wdata_q     <= '0;
      k_q         <= '0;
      c_q         <= '0;
      lat_q       <= 1'b0;
      buf_q       <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      if_data_q   <= '0;
      mem_done_q  <= 1'b0;
      mem_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else if (!rdy_in) begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
    end else begin
      owner_if_q  <= owner_if_d;
      addr_q      <= addr_d;
      n_q         <= n_d;
      wdata_q     <= wdata_d;
      k_q         <= k_d;
      c_q         <= c_d;
      lat_q       <= lat_d;
      buf_q       <= buf_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_done_q   <= if_done_d;
      if_data_q   <= if_data_d;
      mem_done_q  <= mem_done_d;
      mem_rdata_q <= mem_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign ram_a_out     = ram_a_q;
  assign ram_dout_out  = ram_dout_q;
  assign ram_wr_out    = ram_wr_q;
  assign if_done_out   = if_done_q;
  assign if_data_out   = if_data_q;
  assign mem_done_out  = mem_done_q;
  assign mem_rdata_out = mem_rdata_q;
  assign busy_out      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a one-cycle-latency byte RAM model.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        if_req_in;
  logic [31:0] if_addr_in;
  logic        if_flush_in;
  logic        if_done_out;
  logic [31:0] if_data_out;
  logic        mem_load_in;
  logic        mem_store_in;
  logic [31:0] mem_addr_in;
  logic [1:0]  mem_width_in;
  logic [31:0] mem_wdata_in;
  logic        mem_done_out;
  logic [31:0] mem_rdata_out;
  logic        busy_out;
  logic [7:0]  ram_din_in;
  logic [7:0]  ram_dout_out;
  logic [31:0] ram_a_out;
  logic        ram_wr_out;

  always #5 clk_in = ~clk_in;

  mem_arbiter #(
    .ADDR_WIDTH (32),
    .MEM_FIRST  (1'b1)
  ) u_dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .if_req_in     (if_req_in),
    .if_addr_in    (if_addr_in),
    .if_flush_in   (if_flush_in),
    .if_done_out   (if_done_out),
    .if_data_out   (if_data_out),
    .mem_load_in   (mem_load_in),
    .mem_store_in  (mem_store_in),
    .mem_addr_in   (mem_addr_in),
    .mem_width_in  (mem_width_in),
    .mem_wdata_in  (mem_wdata_in),
    .mem_done_out  (mem_done_out),
    .mem_rdata_out (mem_rdata_out),
    .busy_out      (busy_out),
    .ram_din_in    (ram_din_in),
    .ram_dout_out  (ram_dout_out),
    .ram_a_out     (ram_a_out),
    .ram_wr_out    (ram_wr_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // RAM model: address sampled at an edge, byte returned for the next cycle
  logic [7:0]  ram [0:65535];
  logic        pl_we = 1'b0;
  logic [15:0] pl_a  = '0;
  logic [7:0]  pl_d  = '0;
  logic [39:0] wr_log[$];

  always @(posedge clk_in) begin
    if (ram_wr_out) begin
      ram[ram_a_out[15:0]] <= ram_dout_out;
      wr_log.push_back({ram_a_out, ram_dout_out});
    end else if (pl_we) begin
      ram[pl_a] <= pl_d;
    end
    ram_din_in <= ram[ram_a_out[15:0]];
  end

  typedef struct {
    bit          chk;
    logic [31:0] data;
  } exp_t;

  exp_t if_sb[$];
  exp_t mem_sb[$];

  always @(negedge clk_in) begin
    exp_t e;
    if (if_done_out) begin
      if (if_sb.size() == 0) begin
        check_eq("if_spurious_done", {31'd0, if_done_out}, 32'd0);
      end else begin
        e = if_sb.pop_front();
        if (e.chk) check_eq("if_data", if_data_out, e.data);
      end
    end
    if (mem_done_out) begin
      if (mem_sb.size() == 0) begin
        check_eq("mem_spurious_done", {31'd0, mem_done_out}, 32'd0);
      end else begin
        e = mem_sb.pop_front();
        if (e.chk) check_eq("mem_rdata", mem_rdata_out, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_we = 1'b1;
    pl_a  = a;
    pl_d  = d;
    tick();
    pl_we = 1'b0;
  endtask

  task automatic push_exp(input bit to_if, input bit chk, input logic [31:0] d);
    exp_t e;
    e.chk  = chk;
    e.data = d;
    if (to_if) if_sb.push_back(e);
    else       mem_sb.push_back(e);
  endtask

  // Counts edges from now until the selected done pulse; -1 on timeout
  task automatic wait_done(input bit want_if, input string tag, input int exp_lat);
    int lat;
    lat = -1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      tick();
      if (want_if ? if_done_out : mem_done_out) lat = i;
    end
    check_eq(tag, lat, exp_lat);
  endtask

  task automatic mem_op(input bit st, input bit ld, input logic [31:0] a, input logic [1:0] w,
                        input logic [31:0] wd, input bit chk, input logic [31:0] exp,
                        input string tag, input int lat);
    mem_store_in = st;
    mem_load_in  = ld;
    mem_addr_in  = a;
    mem_width_in = w;
    mem_wdata_in = wd;
    push_exp(1'b0, chk, exp);
    tick();
    wait_done(1'b0, tag, lat);
    mem_store_in = 1'b0;
    mem_load_in  = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] snap_a;
    logic [7:0]  snap_d;
    logic        snap_w;

    rst_in       = 1'b1;
    rdy_in       = 1'b1;
    if_req_in    = 1'b0;
    if_addr_in   = '0;
    if_flush_in  = 1'b0;
    mem_load_in  = 1'b0;
    mem_store_in = 1'b0;
    mem_addr_in  = '0;
    mem_width_in = '0;
    mem_wdata_in = '0;

    preload(16'h0100, 8'h13);
    preload(16'h0101, 8'h05);
    preload(16'h0102, 8'h00);
    preload(16'h0103, 8'h00);
    preload(16'h00FF, 8'hAA);
    preload(16'h0104, 8'h77);
    preload(16'h0020, 8'h80);
    preload(16'h0200, 8'h11);
    preload(16'h0201, 8'h22);
    preload(16'h0202, 8'h33);
    preload(16'h0203, 8'h44);
    preload(16'hFFFF, 8'h34);
    preload(16'h0000, 8'h12);
    tick();

    check_eq("rst_busy", {31'd0, busy_out}, 32'd0);
    check_eq("rst_ram_a", ram_a_out, 32'd0);
    check_eq("rst_ram_wr", {31'd0, ram_wr_out}, 32'd0);
    check_eq("rst_if_data", if_data_out, 32'd0);
    rst_in = 1'b0;
    tick();

    // 1: instruction fetch of a word
    if_req_in  = 1'b1;
    if_addr_in = 32'h100;
    push_exp(1'b1, 1'b1, 32'h0000_0513);
    tick();
    check_eq("t1_ram_a_accept", ram_a_out, 32'h100);
    check_eq("t1_ram_wr_read", {31'd0, ram_wr_out}, 32'd0);
    wait_done(1'b1, "t1_if_latency", 5);
    if_req_in = 1'b0;
    tick();

    // 2: halfword store
    wr_log.delete();
    mem_store_in = 1'b1;
    mem_addr_in  = 32'h1002;
    mem_width_in = 2'd1;
    mem_wdata_in = 32'h0000_BEEF;
    push_exp(1'b0, 1'b0, 32'd0);
    tick();
    wait_done(1'b0, "t2_sh_latency", 2);
    check_eq("t2_ram_wr_in_done", {31'd0, ram_wr_out}, 32'd0);
    check_eq("t2_busy_in_done", {31'd0, busy_out}, 32'd1);
    mem_store_in = 1'b0;
    tick();
    check_eq("t2_busy_idle", {31'd0, busy_out}, 32'd0);
    check_eq("t2_wr_count", wr_log.size(), 32'd2);
    check_eq("t2_wr0", wr_log[0][31:0], 32'h0010_02EF);
    check_eq("t2_wr1", wr_log[1][31:0], 32'h0010_03BE);

    // 3: simultaneous IF and MEM load, MEM wins
    mem_load_in  = 1'b1;
    mem_addr_in  = 32'h20;
    mem_width_in = 2'd0;
    if_req_in    = 1'b1;
    if_addr_in   = 32'h100;
    push_exp(1'b0, 1'b1, 32'h0000_0080);
    push_exp(1'b1, 1'b1, 32'h0000_0513);
    tick();
    wait_done(1'b0, "t3_lb_latency", 2);
    mem_load_in = 1'b0;
    wait_done(1'b1, "t3_if_after_lb", 7);
    if_req_in = 1'b0;
    tick();

    // 4: flush after two bytes, then fresh fetch
    if_req_in  = 1'b1;
    if_addr_in = 32'h200;
    tick();
    tick();
    tick();
    tick();
    if_flush_in = 1'b1;
    tick();
    check_eq("t4_busy_after_flush", {31'd0, busy_out}, 32'd0);
    check_eq("t4_no_if_done", {31'd0, if_done_out}, 32'd0);
    if_flush_in = 1'b0;
    if_addr_in  = 32'h100;
    push_exp(1'b1, 1'b1, 32'h0000_0513);
    tick();
    wait_done(1'b1, "t4_refetch_latency", 5);
    if_req_in = 1'b0;
    tick();

    // 5: rdy stall in the middle of a word store
    mem_store_in = 1'b1;
    mem_addr_in  = 32'h3000;
    mem_width_in = 2'd2;
    mem_wdata_in = 32'hDEAD_BEEF;
    push_exp(1'b0, 1'b0, 32'd0);
    tick();
    tick();
    rdy_in = 1'b0;
    snap_a = ram_a_out;
    snap_d = ram_dout_out;
    snap_w = ram_wr_out;
    check_eq("t5_snap_a", snap_a, 32'h3001);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t5_frozen_ram", {ram_a_out[22:0], ram_dout_out, ram_wr_out},
               {snap_a[22:0], snap_d, snap_w});
    end
    rdy_in = 1'b1;
    wait_done(1'b0, "t5_sw_latency_after_stall", 3);
    mem_store_in = 1'b0;
    tick();
    check_eq("t5_sw_bytes", {ram[16'h3003], ram[16'h3002], ram[16'h3001], ram[16'h3000]},
             32'hDEAD_BEEF);

    // 6: reset during a word read
    if_req_in  = 1'b1;
    if_addr_in = 32'h200;
    tick();
    tick();
    tick();
    rst_in = 1'b1;
    tick();
    check_eq("t6_busy", {31'd0, busy_out}, 32'd0);
    check_eq("t6_ram_a", ram_a_out, 32'd0);
    check_eq("t6_ram_wr", {31'd0, ram_wr_out}, 32'd0);
    check_eq("t6_if_done", {31'd0, if_done_out}, 32'd0);
    check_eq("t6_if_data", if_data_out, 32'd0);
    check_eq("t6_mem_rdata", mem_rdata_out, 32'd0);
    rst_in    = 1'b0;
    if_req_in = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check_eq("t6_idle_after", {31'd0, busy_out}, 32'd0);

    // 7: halfword load wrapping past the top of the address space
    mem_op(1'b0, 1'b1, 32'hFFFF_FFFF, 2'd1, 32'd0, 1'b1, 32'h0000_1234, "t7_lh_wrap_latency", 3);

    // 8: width code 3 behaves as a word
    mem_op(1'b0, 1'b1, 32'h200, 2'd3, 32'd0, 1'b1, 32'h4433_2211, "t8_w3_latency", 5);

    // 9: store and load together, store taken
    wr_log.delete();
    mem_op(1'b1, 1'b1, 32'h40, 2'd0, 32'h0000_005A, 1'b0, 32'd0, "t9_sb_latency", 1);
    check_eq("t9_wr_count", wr_log.size(), 32'd1);
    check_eq("t9_wr0", wr_log[0][31:0], 32'h0000_405A);

    // 10: fetch with flush held is never accepted
    if_req_in   = 1'b1;
    if_flush_in = 1'b1;
    if_addr_in  = 32'h100;
    tick();
    tick();
    check_eq("t10_flush_blocks_accept", {31'd0, busy_out}, 32'd0);
    if_req_in   = 1'b0;
    if_flush_in = 1'b0;
    tick();

    check_eq("sb_if_empty", if_sb.size(), 32'd0);
    check_eq("sb_mem_empty", mem_sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
